// File: rtl/seven_segment_capture_if.sv
// Scanned seven-segment display bus plus the
// reconstructed frame returned by the capture block.
interface seven_segment_capture_if #(
  parameter int DIGITS = 4
);
  logic [DIGITS-1:0]   anode;
  logic [6:0]          segment;
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   blank;
  logic                error;
  logic                valid;

  modport master (
    output anode, segment,
    input  value, blank, error, valid
  );

  modport slave (
    input  anode, segment,
    output value, blank, error, valid
  );
endinterface

// File: rtl/seven_segment_capture.sv
// Watches a multiplexed active-low seven-segment bus
// and rebuilds the displayed hex value frame by frame.
module seven_segment_capture #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input logic clk,
  input logic reset,
  seven_segment_capture_if.slave bus
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] C_SAT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] C_ARM = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [DIGITS-1:0] D_ONE = DIGITS'(1);

  logic [DIGITS-1:0]   r_an_s1;
  logic [DIGITS-1:0]   r_an_s2;
  logic [6:0]          r_seg_s1;
  logic [6:0]          r_seg_s2;
  logic [CW-1:0]       r_cnt;
  logic [4*DIGITS-1:0] r_shadow;
  logic [DIGITS-1:0]   r_sblank;
  logic [DIGITS-1:0]   r_seen;
  logic                r_bad;
  logic                r_done;
  logic [4*DIGITS-1:0] r_value;
  logic [DIGITS-1:0]   r_blank;
  logic                r_error;
  logic                r_valid;

  logic [DIGITS-1:0] w_act;
  logic              w_sel;
  logic              w_same;
  logic              w_inc;
  logic              w_cap;
  logic [DIGITS-1:0] w_cap_mask;
  logic [DIGITS-1:0] w_seen_next;
  logic              w_bad_next;
  logic              w_done_next;
  logic [3:0]        w_nib;
  logic              w_dark;
  logic              w_undec;

  assign bus.value = r_value;
  assign bus.blank = r_blank;
  assign bus.error = r_error;
  assign bus.valid = r_valid;

  // The sample entering the second stage is compared with
  // the one already there, so the dwell count tracks the
  // sample the moment it becomes S.
  assign w_act  = ~r_an_s1;
  assign w_sel  = (w_act != '0) &&
                  ((w_act & (w_act - D_ONE)) == '0);
  assign w_same = (r_an_s1 == r_an_s2) &&
                  (r_seg_s1 == r_seg_s2);
  assign w_inc  = w_same && w_sel;
  assign w_cap  = w_inc && (r_cnt == C_ARM);

  assign w_cap_mask  = w_cap ? w_act : '0;
  assign w_seen_next = (r_done ? '0 : r_seen) | w_cap_mask;
  assign w_bad_next  = (r_done ? 1'b0 : r_bad) |
                       (w_cap & w_undec);
  assign w_done_next = w_cap && (&w_seen_next);

  // Map an active-low {g..a} pattern back to a nibble.
  always_comb begin
    w_nib   = 4'h0;
    w_dark  = 1'b0;
    w_undec = 1'b0;
    unique case (r_seg_s1)
      7'b1000000: w_nib = 4'h0;
      7'b1111001: w_nib = 4'h1;
      7'b0100100: w_nib = 4'h2;
      7'b0110000: w_nib = 4'h3;
      7'b0011001: w_nib = 4'h4;
      7'b0010010: w_nib = 4'h5;
      7'b0000010: w_nib = 4'h6;
      7'b1111000: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0010000: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b0000011: w_nib = 4'hB;
      7'b1000110: w_nib = 4'hC;
      7'b0100001: w_nib = 4'hD;
      7'b0000110: w_nib = 4'hE;
      7'b0001110: w_nib = 4'hF;
      7'b1111111: w_dark = 1'b1;
      default:    w_undec = 1'b1;
    endcase
  end

  // Two-flop synchronizers, idle (all off) out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an_s1  <= '1;
      r_an_s2  <= '1;
      r_seg_s1 <= '1;
      r_seg_s2 <= '1;
    end else begin
      r_an_s1  <= bus.anode;
      r_an_s2  <= r_an_s1;
      r_seg_s1 <= bus.segment;
      r_seg_s2 <= r_seg_s1;
    end
  end

  // Saturating dwell counter of identical selectable samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!w_inc) begin
      r_cnt <= '0;
    end else if (r_cnt != C_SAT) begin
      r_cnt <= r_cnt + C_ONE;
    end
  end

  // Record captured digits into the frame being assembled.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
      r_sblank <= '0;
      r_seen   <= '0;
      r_bad    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_seen <= w_seen_next;
      r_bad  <= w_bad_next;
      r_done <= w_done_next;
      for (int k = 0; k < DIGITS; k++) begin
        if (w_cap_mask[k]) begin
          r_shadow[4*k +: 4] <= w_nib;
          r_sblank[k]        <= w_dark;
        end
      end
    end
  end

  // Publish a completed frame and pulse valid once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_value <= '0;
      r_blank <= '0;
      r_error <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_done;
      if (r_done) begin
        r_value <= r_shadow;
        r_blank <= r_sblank;
        r_error <= r_bad;
      end
    end
  end
endmodule
